ar_tag_allocator: RTL
=====================

# ar_tag_allocator

Upstream neighbour of the outgoing AR request buffer in the read-reorder path. Accepts AXI read-address requests from the master side and allocates a free internal tag to each. Records the original ID and burst length per tag, then forwards the tagged request through a one-entry registered output stage. Tags are returned by the response-side ROB logic on the last data beat, and that logic reads back the original ID through a lookup port.

## Interface
- ID_WIDTH, 4: AXI ID width
- ADDR_WIDTH, 32: address width
- LEN_WIDTH, 8: burst length width
- TAG_WIDTH, 4: tag width; pool holds NUM_TAGS = 2**TAG_WIDTH tags
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (asserted when rst==0)
- in_if  ar_if.receiver  —  request from AXI master; tagid field ignored
- out_if  ar_if.sender  —  tagged request to outgoing AR request buffer
- free_valid  in  1  tag release strobe
- free_tag  in  TAG_WIDTH  tag being released
- lookup_tag  in  TAG_WIDTH  tag to look up
- lookup_id  out  ID_WIDTH  original ID stored for lookup_tag
- lookup_len  out  LEN_WIDTH  burst len stored for lookup_tag
- outstanding  out  TAG_WIDTH+1  number of allocated tags
- err_double_free  out  1  sticky: release of a tag that was not allocated

## Operation
- State: busy bitmap (NUM_TAGS bits), id/len table (NUM_TAGS entries), output register (valid plus all ar_if fields), outstanding counter, error flag.
- Free-tag select: lowest-index tag with busy==0, from a priority encoder on the registered bitmap. tags_avail = any busy bit clear.
- in_if.ready = tags_avail && (!out_if.valid || out_if.ready). Combinational from registered state and out_if.ready only; never from in_if.valid.
- Accept (in_if.valid && in_if.ready), at the edge:
  - set busy[sel]
  - write table[sel] = {in_if.id, in_if.len}
  - load the output register with id, addr, len, size, burst and qos unchanged, tagid=sel, valid=1
  - increment outstanding
- Output handshake: out_if.valid holds with stable fields until out_if.ready. If out_if.ready is high and no new accept occurs, valid drops to 0 next cycle. Accept and drain in the same cycle give back-to-back output with no bubble.
- Release (free_valid), at the edge:
  - if busy[free_tag]==1: clear it and decrement outstanding
  - else: ignore the release and set err_double_free
- A released tag is not allocatable until the cycle after the release edge, because select uses registered busy.
- Simultaneous accept and release: both apply. outstanding stays unchanged. If both name the same tag, which is impossible since sel is free, the release is treated as a double free.
- Lookup: lookup_id/lookup_len are a combinational table read. Values are defined only while the tag is busy. Table contents are not cleared on release.
- outstanding never exceeds NUM_TAGS and never underflows.

## Timing
- Reset (rst==0 at an edge) clears:
  - out_if.valid=0 and out_if data fields=0
  - busy=0 and outstanding=0
  - err_double_free=0
  Table contents are not reset. in_if.ready=1 in the first cycle after reset release.
- Reset mid-operation drops any pending out_if request and frees all tags. Releases arriving during reset are ignored.
- Latency: in_if accept at edge N makes out_if.valid high after edge N.
- Throughput: one request per cycle while tags are free and the downstream is ready.
- Pool exhausted (outstanding==NUM_TAGS): in_if.ready=0. It rises in the cycle after the first valid release edge.
- Full pool plus a release plus a downstream stall: ready stays 0 while out_if.valid && !out_if.ready.

## Test plan
- Reset, then 3 back-to-back requests (ids 2,5,2; addr 0x100/0x200/0x300), out_if.ready=1 → out_if shows tagid 0,1,2 on consecutive cycles; outstanding=3; lookup_tag=1 gives lookup_id=5.
- Issue 16 requests with ready=1 and no releases → 17th sees in_if.ready=0. Release tag 7 → ready=1 one cycle later, next request gets tagid 7, outstanding back to 16.
- out_if.ready=0 for 4 cycles with a request pending → out_if fields stable, in_if.ready=0, second request waits. Raise ready → both requests emitted in consecutive cycles.
- Accept and release of tag 0 in the same cycle with outstanding=5 → outstanding stays 5; new request receives the lowest free tag, not tag 0 in that cycle.
- Release tag 9 while it is free → err_double_free=1 and sticky; outstanding unchanged. Reset clears the flag.
- Reset asserted while 4 tags are busy and out_if.valid=1 → next cycle out_if.valid=0, outstanding=0, first new request gets tagid 0.

Source files
------------

// File: rtl/ar_tag_allocator_if.sv
// AXI read-address channel bundle carrying an internal tag alongside the AXI fields.
interface ar_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
    logic [TAG_WIDTH-1:0]  tagid;

    modport sender   (output valid, id, addr, len, size, burst, qos, tagid, input ready);
    modport receiver (input valid, id, addr, len, size, burst, qos, tagid, output ready);
endinterface

// File: rtl/ar_tag_allocator.sv
// Allocates a free internal tag per AR request, records id/len per tag and
// forwards the tagged request through a one-entry registered output stage.
module ar_tag_allocator #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ar_if.receiver               in_if,
    ar_if.sender                 out_if,
    input  logic                 free_valid,
    input  logic [TAG_WIDTH-1:0] free_tag,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    output logic [ID_WIDTH-1:0]  lookup_id,
    output logic [LEN_WIDTH-1:0] lookup_len,
    output logic [TAG_WIDTH:0]   outstanding,
    output logic                 err_double_free
);
    localparam int unsigned NUM_TAGS = 2 ** TAG_WIDTH;

    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [TAG_WIDTH:0]    outstanding_q, outstanding_d;
    logic                  err_q, err_d;
    logic [ID_WIDTH-1:0]   id_tab_q [NUM_TAGS];
    logic [ID_WIDTH-1:0]   id_tab_d [NUM_TAGS];
    logic [LEN_WIDTH-1:0]  len_tab_q [NUM_TAGS];
    logic [LEN_WIDTH-1:0]  len_tab_d [NUM_TAGS];

    logic                  out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
    logic [2:0]            out_size_q, out_size_d;
    logic [1:0]            out_burst_q, out_burst_d;
    logic [3:0]            out_qos_q, out_qos_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

    logic [TAG_WIDTH-1:0]  sel;
    logic                  tags_avail;
    logic                  in_ready;
    logic                  accept;
    logic                  free_hit;
    logic                  unused_tagid;

    assign unused_tagid = ^in_if.tagid;

    // Scan downwards so the lowest free index is the last one assigned.
    always_comb begin
        sel = '0;
        for (int unsigned i = NUM_TAGS; i > 0; i--) begin
            if (!busy_q[TAG_WIDTH'(i - 1)]) sel = TAG_WIDTH'(i - 1);
        end
    end

    assign tags_avail = ~&busy_q;
    assign in_ready   = tags_avail && (!out_valid_q || out_if.ready);
    assign accept     = in_if.valid && in_ready;
    assign free_hit   = free_valid && busy_q[free_tag];

    always_comb begin
        busy_d    = busy_q;
        id_tab_d  = id_tab_q;
        len_tab_d = len_tab_q;
        if (accept) begin
            busy_d[sel]    = 1'b1;
            id_tab_d[sel]  = in_if.id;
            len_tab_d[sel] = in_if.len;
        end
        // sel is never busy, so a hit can never target the tag being allocated.
        if (free_hit) busy_d[free_tag] = 1'b0;
        outstanding_d = outstanding_q + (TAG_WIDTH + 1)'(accept) - (TAG_WIDTH + 1)'(free_hit);
        err_d         = err_q || (free_valid && !busy_q[free_tag]);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_addr_d  = out_addr_q;
        out_len_d   = out_len_q;
        out_size_d  = out_size_q;
        out_burst_d = out_burst_q;
        out_qos_d   = out_qos_q;
        out_tag_d   = out_tag_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_id_d    = in_if.id;
            out_addr_d  = in_if.addr;
            out_len_d   = in_if.len;
            out_size_d  = in_if.size;
            out_burst_d = in_if.burst;
            out_qos_d   = in_if.qos;
            out_tag_d   = sel;
        end else if (out_if.ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_id_q      <= '0;
            out_addr_q    <= '0;
            out_len_q     <= '0;
            out_size_q    <= '0;
            out_burst_q   <= '0;
            out_qos_q     <= '0;
            out_tag_q     <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            out_addr_q    <= out_addr_d;
            out_len_q     <= out_len_d;
            out_size_q    <= out_size_d;
            out_burst_q   <= out_burst_d;
            out_qos_q     <= out_qos_d;
            out_tag_q     <= out_tag_d;
        end
    end

    // Table is not reset; entries are only meaningful while their tag is busy.
    always_ff @(posedge clk) begin
        id_tab_q  <= id_tab_d;
        len_tab_q <= len_tab_d;
    end

    assign in_if.ready     = in_ready;
    assign out_if.valid    = out_valid_q;
    assign out_if.id       = out_id_q;
    assign out_if.addr     = out_addr_q;
    assign out_if.len      = out_len_q;
    assign out_if.size     = out_size_q;
    assign out_if.burst    = out_burst_q;
    assign out_if.qos      = out_qos_q;
    assign out_if.tagid    = out_tag_q;
    assign lookup_id       = id_tab_q[lookup_tag];
    assign lookup_len      = len_tab_q[lookup_tag];
    assign outstanding     = outstanding_q;
    assign err_double_free = err_q;
endmodule
